// File: rtl/ftdl_pkg.sv
// Shared types and default widths for the activation-buffer feeder.
// DATA_W is one actbuf row: HW_D1 lanes of ACTBUF_LANE_W bits each.
`ifndef HW_D1
`define HW_D1 8
`endif
`ifndef ACTBUF_LANE_W
`define ACTBUF_LANE_W 8
`endif
`ifndef ACTBUF_CNT_W
`define ACTBUF_CNT_W 16
`endif

package ftdl_pkg;

    localparam int DATA_W_DEF     = `HW_D1 * `ACTBUF_LANE_W;
    localparam int CNT_W_DEF      = `ACTBUF_CNT_W;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/act_skid_fifo.sv
// Small synchronous FIFO between the DMA stream and the actbuf write port.
// Storage is cleared on reset so the head reads zero after a reset.
module act_skid_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/actbuf_feeder.sv
// Buffers DMA activation words and releases them to the actbuf write port
// in bursts of cfg_burst_len words while the controller requests them.
module actbuf_feeder
    import ftdl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk_l,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_burst_len,
    input  logic [CNT_W-1:0]  cfg_num_bursts,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              actbuf_wr_req,
    output logic              actbuf_wr_vld,
    output logic [DATA_W-1:0] actbuf_wr_data,
    output logic              burst_done,
    output logic              done,
    output logic              busy,
    output logic              err_cfg,
    output logic [CNT_W-1:0]  underrun_cnt
);

    feeder_state_e state;
    feeder_state_e next_state;

    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  burst_cnt;
    logic              rdy_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              transfer;
    logic              cfg_ok;
    logic              start_acc;
    logic              start_bad;
    logic              last_word;
    logic              last_burst;
    logic              underrun;

    act_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_l),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (transfer),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // rdy_en keeps in_rdy low while in reset and for the first cycle after it.
    assign in_rdy         = rdy_en & ~fifo_full;
    assign push           = in_vld & in_rdy;
    assign actbuf_wr_vld  = (state == BURST) & actbuf_wr_req & ~fifo_empty;
    assign actbuf_wr_data = fifo_head;
    assign transfer       = actbuf_wr_req & actbuf_wr_vld;

    assign cfg_ok     = (cfg_burst_len != '0) && (cfg_num_bursts != '0);
    assign start_acc  = start && (state == IDLE) && cfg_ok;
    assign start_bad  = start && (state == IDLE) && !cfg_ok;
    assign last_word  = (word_cnt == len_q - 1'b1);
    assign last_burst = (burst_cnt == num_q - 1'b1);
    assign underrun   = (state == BURST) && actbuf_wr_req && fifo_empty;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The done pulse is high exactly in the GAP cycle that ends the job.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_acc) next_state = BURST;
            BURST:   if (transfer && last_word) next_state = GAP;
            GAP:     next_state = done ? IDLE : BURST;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            num_q        <= '0;
            word_cnt     <= '0;
            burst_cnt    <= '0;
            rdy_en       <= 1'b0;
            burst_done   <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err_cfg      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            rdy_en     <= 1'b1;
            burst_done <= 1'b0;
            done       <= 1'b0;
            err_cfg    <= start_bad;
            if (start_acc) begin
                len_q     <= cfg_burst_len;
                num_q     <= cfg_num_bursts;
                word_cnt  <= '0;
                burst_cnt <= '0;
                busy      <= 1'b1;
            end
            if (transfer) begin
                if (last_word) begin
                    word_cnt   <= '0;
                    burst_done <= 1'b1;
                    if (last_burst) begin
                        burst_cnt <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (underrun && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_actbuf_feeder.sv
// Self-checking bench for actbuf_feeder: random data against a queue-based
// reference model of the burst/job rules, plus per-scenario totals.
module tb_actbuf_feeder;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 4;

    logic              clk_l = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  cfg_burst_len;
    logic [CNT_W-1:0]  cfg_num_bursts;
    logic [DATA_W-1:0] in_data;
    logic              in_vld;
    logic              in_rdy;
    logic              actbuf_wr_req;
    logic              actbuf_wr_vld;
    logic [DATA_W-1:0] actbuf_wr_data;
    logic              burst_done;
    logic              done;
    logic              busy;
    logic              err_cfg;
    logic [CNT_W-1:0]  underrun_cnt;

    always #5 clk_l = ~clk_l;

    actbuf_feeder #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_l          (clk_l),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_num_bursts (cfg_num_bursts),
        .in_data        (in_data),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .actbuf_wr_req  (actbuf_wr_req),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .actbuf_wr_data (actbuf_wr_data),
        .burst_done     (burst_done),
        .done           (done),
        .busy           (busy),
        .err_cfg        (err_cfg),
        .underrun_cnt   (underrun_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as a queue, job progress as plain counts.
    logic [DATA_W-1:0] m_q[$];
    bit m_active, m_busy, m_bd, m_done, m_err, m_rdy_ok;
    int m_len, m_nb, m_words, m_bursts, m_underrun;

    int obs_words, obs_bd, obs_done;
    bit o_vld_last, o_rdy_last, o_err_last, o_busy_last;

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_busy = 0; m_bd = 0; m_done = 0; m_err = 0;
        m_rdy_ok = 0; m_len = 0; m_nb = 0; m_words = 0; m_bursts = 0;
        m_underrun = 0;
    endtask

    task automatic clear_obs();
        obs_words = 0; obs_bd = 0; obs_done = 0;
    endtask

    // One clock cycle: drive inputs, compare every output to the model, advance the model.
    task automatic run_cycle(input bit st, input int len, input int nb,
                             input bit req, input bit dvld, input string tag);
        logic [DATA_W-1:0] d;
        bit e_vld, e_rdy, und, xfer, push, cur_active, nbd, ndone, nerr;
        @(negedge clk_l);
        d = {$urandom, $urandom};
        start          = st;
        cfg_burst_len  = st ? CNT_W'(len) : CNT_W'($urandom);
        cfg_num_bursts = st ? CNT_W'(nb)  : CNT_W'($urandom);
        actbuf_wr_req  = req;
        in_vld         = dvld;
        in_data        = d;
        #1;
        e_vld = m_active && !m_bd && req && (m_q.size() > 0);
        e_rdy = m_rdy_ok && (m_q.size() < DEPTH);
        und   = m_active && !m_bd && req && (m_q.size() == 0);

        n_checks++;
        if (actbuf_wr_vld !== e_vld) begin
            n_fail++;
            $display("[TB] FAIL %s wr_vld got %b want %b at %0t", tag, actbuf_wr_vld, e_vld, $time);
        end
        if (e_vld) begin
            n_checks++;
            if (actbuf_wr_data !== m_q[0]) begin
                n_fail++;
                $display("[TB] FAIL %s wr_data got %h want %h at %0t", tag, actbuf_wr_data, m_q[0], $time);
            end
        end
        n_checks++;
        if (in_rdy !== e_rdy) begin
            n_fail++;
            $display("[TB] FAIL %s in_rdy got %b want %b at %0t", tag, in_rdy, e_rdy, $time);
        end
        n_checks++;
        if (burst_done !== m_bd) begin
            n_fail++;
            $display("[TB] FAIL %s burst_done got %b want %b at %0t", tag, burst_done, m_bd, $time);
        end
        n_checks++;
        if (done !== m_done) begin
            n_fail++;
            $display("[TB] FAIL %s done got %b want %b at %0t", tag, done, m_done, $time);
        end
        n_checks++;
        if (busy !== m_busy) begin
            n_fail++;
            $display("[TB] FAIL %s busy got %b want %b at %0t", tag, busy, m_busy, $time);
        end
        n_checks++;
        if (err_cfg !== m_err) begin
            n_fail++;
            $display("[TB] FAIL %s err_cfg got %b want %b at %0t", tag, err_cfg, m_err, $time);
        end
        n_checks++;
        if (underrun_cnt !== CNT_W'(m_underrun)) begin
            n_fail++;
            $display("[TB] FAIL %s underrun_cnt got %0d want %0d at %0t", tag, underrun_cnt, m_underrun, $time);
        end

        o_vld_last  = actbuf_wr_vld;
        o_rdy_last  = in_rdy;
        o_err_last  = err_cfg;
        o_busy_last = busy;
        if (actbuf_wr_vld === 1'b1) obs_words++;
        if (burst_done === 1'b1) obs_bd++;
        if (done === 1'b1) obs_done++;

        xfer = e_vld;
        push = dvld && e_rdy;
        cur_active = m_active;
        @(posedge clk_l);
        nbd = 0; ndone = 0; nerr = 0;
        if (und && m_underrun < 65535) m_underrun++;
        if (m_bd && m_done) m_active = 0;
        if (xfer) begin
            void'(m_q.pop_front());
            m_words++;
            if (m_words == m_len) begin
                m_words = 0;
                m_bursts++;
                nbd = 1;
                if (m_bursts == m_nb) begin
                    ndone = 1;
                    m_busy = 0;
                    m_bursts = 0;
                end
            end
        end
        if (st && !cur_active) begin
            if (len == 0 || nb == 0) begin
                nerr = 1;
            end else begin
                m_active = 1; m_busy = 1; m_len = len; m_nb = nb;
                m_words = 0; m_bursts = 0;
            end
        end
        if (push) m_q.push_back(d);
        m_bd = nbd; m_done = ndone; m_err = nerr; m_rdy_ok = 1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic apply_reset(input string tag);
        @(negedge clk_l);
        #2;
        rst_n = 1'b0;
        start = 1'b0; actbuf_wr_req = 1'b0; in_vld = 1'b0;
        #1;
        n_checks++;
        if ({in_rdy, actbuf_wr_vld, burst_done, done, busy, err_cfg} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL %s reset_flags got rdy=%b vld=%b bd=%b done=%b busy=%b err=%b want all 0",
                     tag, in_rdy, actbuf_wr_vld, burst_done, done, busy, err_cfg);
        end
        n_checks++;
        if (actbuf_wr_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s reset_data got %h want 0", tag, actbuf_wr_data);
        end
        n_checks++;
        if (underrun_cnt !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s reset_underrun got %0d want 0", tag, underrun_cnt);
        end
        model_reset();
        @(negedge clk_l);
        rst_n = 1'b1;
        @(posedge clk_l);
        m_rdy_ok = 1;
    endtask

    task automatic prefill(input int n, input string tag);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 1, tag);
    endtask

    task automatic check_totals(input string tag, input int words, input int bds, input int dones);
        n_checks++;
        if (obs_words != words || obs_bd != bds || obs_done != dones) begin
            n_fail++;
            $display("[TB] FAIL %s totals got words=%0d bd=%0d done=%0d want words=%0d bd=%0d done=%0d",
                     tag, obs_words, obs_bd, obs_done, words, bds, dones);
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
        run_cycle(0, 0, 0, 0, 0, "reset");
        n_checks++;
        if (o_rdy_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset in_rdy_after got %b want 1", o_rdy_last);
        end
    endtask

    task automatic test_happy_path();
        apply_reset("happy");
        prefill(4, "happy");
        clear_obs();
        run_cycle(1, 27, 2, 1, 1, "happy");
        for (int c = 0; c < 200 && obs_done == 0; c++) run_cycle(0, 0, 0, 1, 1, "happy");
        check_totals("happy", 54, 2, 1);
    endtask

    task automatic test_req_drop();
        int drop = 0;
        int drop_vld = 0;
        bit dropped = 0;
        bit req;
        apply_reset("req_drop");
        prefill(4, "req_drop");
        clear_obs();
        run_cycle(1, 27, 2, 1, 1, "req_drop");
        for (int c = 0; c < 300 && obs_done == 0; c++) begin
            if (!dropped && m_active && m_bursts == 0 && m_words == 10) begin
                drop = 5;
                dropped = 1;
            end
            req = (drop == 0);
            if (drop > 0) drop--;
            run_cycle(0, 0, 0, req, 1, "req_drop");
            if (!req && o_vld_last) drop_vld++;
        end
        n_checks++;
        if (drop_vld != 0 || !dropped) begin
            n_fail++;
            $display("[TB] FAIL req_drop vld_during_drop got %0d (dropped=%b) want 0", drop_vld, dropped);
        end
        check_totals("req_drop", 54, 2, 1);
    endtask

    task automatic test_underrun();
        apply_reset("underrun");
        clear_obs();
        run_cycle(1, 27, 1, 1, 0, "underrun");
        for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 1, 0, "underrun");
        #1;
        n_checks++;
        if (underrun_cnt !== CNT_W'(8)) begin
            n_fail++;
            $display("[TB] FAIL underrun count got %0d want 8", underrun_cnt);
        end
        run_cycle(0, 0, 0, 0, 1, "underrun");
        run_cycle(0, 0, 0, 1, 1, "underrun");
        n_checks++;
        if (o_vld_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL underrun resume_vld got %b want 1", o_vld_last);
        end
        for (int c = 0; c < 100 && obs_done == 0; c++) run_cycle(0, 0, 0, 1, 1, "underrun");
        check_totals("underrun", 27, 1, 1);
        n_checks++;
        if (underrun_cnt !== CNT_W'(8)) begin
            n_fail++;
            $display("[TB] FAIL underrun final got %0d want 8", underrun_cnt);
        end
    endtask

    task automatic test_cfg_error();
        apply_reset("cfg_err");
        clear_obs();
        run_cycle(1, 0, 3, 1, 0, "cfg_err");
        run_cycle(0, 0, 0, 1, 0, "cfg_err");
        n_checks++;
        if (o_err_last !== 1'b1 || o_busy_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cfg_err zero_len got err=%b busy=%b want err=1 busy=0", o_err_last, o_busy_last);
        end
        run_cycle(1, 5, 0, 1, 0, "cfg_err");
        run_cycle(0, 0, 0, 0, 0, "cfg_err");
        n_checks++;
        if (o_err_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cfg_err zero_bursts got err=%b want 1", o_err_last);
        end
        prefill(3, "cfg_err");
        run_cycle(1, 3, 1, 0, 0, "cfg_err");
        run_cycle(1, 9, 9, 0, 0, "cfg_err");
        run_cycle(0, 0, 0, 0, 0, "cfg_err");
        n_checks++;
        if (o_err_last !== 1'b0 || o_busy_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cfg_err busy_start got err=%b busy=%b want err=0 busy=1", o_err_last, o_busy_last);
        end
        for (int c = 0; c < 50 && obs_done == 0; c++) run_cycle(0, 0, 0, 1, 0, "cfg_err");
        check_totals("cfg_err", 3, 1, 1);
    endtask

    task automatic test_fifo_full();
        apply_reset("fifo_full");
        prefill(4, "fifo_full");
        run_cycle(0, 0, 0, 0, 1, "fifo_full");
        n_checks++;
        if (o_rdy_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fifo_full fifth_rdy got %b want 0", o_rdy_last);
        end
        clear_obs();
        run_cycle(1, 8, 1, 0, 0, "fifo_full");
        run_cycle(0, 0, 0, 1, 0, "fifo_full");
        n_checks++;
        if (o_rdy_last !== 1'b0 || o_vld_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fifo_full pop_when_full got rdy=%b vld=%b want rdy=0 vld=1", o_rdy_last, o_vld_last);
        end
        run_cycle(0, 0, 0, 1, 1, "fifo_full");
        n_checks++;
        if (o_rdy_last !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fifo_full rdy_after_pop got %b want 1", o_rdy_last);
        end
        run_cycle(0, 0, 0, 0, 1, "fifo_full");
        run_cycle(0, 0, 0, 0, 0, "fifo_full");
        n_checks++;
        if (o_rdy_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fifo_full refilled_rdy got %b want 0", o_rdy_last);
        end
        for (int c = 0; c < 60 && obs_done == 0; c++) run_cycle(0, 0, 0, 1, 1, "fifo_full");
        check_totals("fifo_full", 8, 1, 1);
    endtask

    task automatic test_reset_mid_burst();
        apply_reset("mid_rst");
        prefill(4, "mid_rst");
        run_cycle(1, 27, 2, 1, 1, "mid_rst");
        for (int c = 0; c < 100 && !(m_active && m_words == 13); c++) run_cycle(0, 0, 0, 1, 1, "mid_rst");
        n_checks++;
        if (m_words != 13) begin
            n_fail++;
            $display("[TB] FAIL mid_rst reach_word13 got %0d want 13", m_words);
        end
        apply_reset("mid_rst");
        clear_obs();
        run_cycle(1, 27, 1, 1, 0, "mid_rst");
        run_cycle(0, 0, 0, 1, 0, "mid_rst");
        n_checks++;
        if (o_vld_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_rst fifo_empty_vld got %b want 0", o_vld_last);
        end
        for (int c = 0; c < 100 && obs_done == 0; c++) run_cycle(0, 0, 0, 1, 1, "mid_rst");
        check_totals("mid_rst", 27, 1, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog time limit reached at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_burst_len = '0;
        cfg_num_bursts = '0;
        in_data = '0;
        in_vld = 1'b0;
        actbuf_wr_req = 1'b0;
        model_reset();
        clear_obs();
        test_reset();
        test_happy_path();
        test_req_drop();
        test_underrun();
        test_cfg_error();
        test_fifo_full();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
